adc_spi_capture: RTL and testbench
==================================

// Module: adc_spi_capture
// PURPOSE
//  SPI master that reads two serial ADCs sharing one chip select and one SCLK.
//  Generates cs1 and SPI_clk from the system clock and samples adc1/adc2 each frame.
//  Emits one 32-bit AXI-Stream beat per frame to the trigger/FFT path.
//  Host side of the ADC interface: the ADC drives a bit after every SCLK rise; this block captures it.
// PARAMETERS
//  CLK_DIV        7   clk cycles per SCLK half-period (SCLK period = 2*CLK_DIV clk cycles)
//  LEAD_BITS      4   SCLK rises before the ADC drives its MSB
//  DATA_BITS      10  sample width per channel, MSB first
//  FRAME_SCLKS    16  SCLK rises per frame; must be >= LEAD_BITS+DATA_BITS
//  QUIET_CYCLES   14  clk cycles with cs1 high between frames
// PORTS
//  clk            in   1   system clock; only clock in the block
//  reset_b        in   1   asynchronous, active-low reset
//  enable         in   1   1 = free-run frames; 0 = stop after the current frame
//  SPI_clk        out  1   SCLK to both ADCs; idles low
//  cs1            out  1   shared chip select, active low
//  adc1           in   1   serial data, channel 1
//  adc2           in   1   serial data, channel 2
//  m_axis_tvalid  out  1   sample beat valid
//  m_axis_tready  in   1   downstream ready
//  m_axis_tdata   out  32  {ch2[15:0], ch1[15:0]}
//  overrun        out  1   1-cycle pulse: frame completed while a beat was still pending
// BEHAVIOUR
//  Reset: cs1=1, SPI_clk=0, m_axis_tvalid=0, m_axis_tdata=0, overrun=0, FSM=IDLE.
//   Reset applies immediately, including mid-frame; the partial frame is discarded.
//  FSM states: IDLE -> QUIET -> SHIFT -> DONE -> QUIET / IDLE.
//   IDLE : cs1=1. Go to QUIET when enable=1.
//   QUIET: cs1=1 for QUIET_CYCLES clk cycles, then cs1 falls and the FSM enters SHIFT.
//   SHIFT: SPI_clk toggles every CLK_DIV clk cycles; first transition is a rise,
//     CLK_DIV cycles after cs1 falls. Rise counter n runs 1..FRAME_SCLKS.
//     adc1/adc2 are sampled on the clk edge that drives the fall following rise n,
//     for n = LEAD_BITS..LEAD_BITS+DATA_BITS-1, shifting left (MSB first).
//     The falling edge after rise FRAME_SCLKS ends SHIFT.
//   DONE : one cycle; cs1=1; publish. Next state is QUIET if enable=1, else IDLE.
//  enable=0 during SHIFT: the frame completes and is published, then IDLE.
//  Publish (DONE cycle, visible on the next clk):
//   - tvalid=0, or tvalid=1 with tready=1 that cycle: load tdata, set tvalid=1.
//   - Otherwise the new frame is dropped, the pending beat is kept, overrun pulses.
//  AXI: tvalid stays high and tdata stays stable until tready=1;
//   tvalid clears on the accepting cycle unless a publish occurs that same cycle.
//  Latency: tvalid rises 1 clk after the last SCLK fall (DONE registered).
//  Width: each channel is zero-extended from DATA_BITS to 16 (default build).
//  Frame period: QUIET_CYCLES + 2*CLK_DIV*FRAME_SCLKS + 1 clk cycles (defaults: 239).
// CONFIGURATION
//  ADC_SIGNED_CONV_EN defined: each channel becomes
//   sign_extend(sample - 2**(DATA_BITS-1)), 16-bit two's complement.
//   Example: 0x200 -> 0x0000; 0x000 -> 0xFE00; 0x3FF -> 0x01FF.
//  Not defined: raw offset-binary, zero-extended.
//  FSM, timing and handshake are identical in both builds.
// TESTING
//  Bench ADC model: on cs1 fall, drive 0 for 4 SCLK rises, then bits 9..0 after each rise.
//  1) enable=1, tready=1, adc1=0x2A5, adc2=0x15A
//     -> tdata=0x015A_02A5, one tvalid pulse per 239 clk, 16 SCLK rises per cs1-low window.
//  2) ADC_SIGNED_CONV_EN build, adc1=0x000, adc2=0x3FF -> tdata=0x01FF_FE00.
//  3) tready=0 over two frames -> first beat held stable, overrun pulses once, second frame lost;
//     raise tready -> first beat accepted, tvalid falls.
//  4) reset_b low at SCLK rise 8 -> cs1=1, SPI_clk=0, tvalid=0 immediately;
//     after release, the next frame is captured correctly.
//  5) enable drops at SCLK rise 3 -> that frame still published, then cs1 stays high with no SCLK.
//  6) Stream 256 ramp samples 0..255 on both channels
//     -> outputs match in order with no gaps or overrun while tready=1.

Source files
------------

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: dual-ADC SPI master, one {ch2,ch1} AXI-S beat per frame, tvalid 1 clk after the last SCLK fall.
// A beat held by tready=0 drops the next frame (overrun pulse). Define ADC_SIGNED_CONV_EN for signed 16-bit samples.
module adc_spi_capture #(
  parameter int CLK_DIV      = 7,
  parameter int LEAD_BITS    = 4,
  parameter int DATA_BITS    = 10,
  parameter int FRAME_SCLKS  = 16,
  parameter int QUIET_CYCLES = 14
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        enable,
  output logic        SPI_clk,
  output logic        cs1,
  input  logic        adc1,
  input  logic        adc2,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        overrun
);

  localparam int CNT_MAX = (QUIET_CYCLES > CLK_DIV) ? QUIET_CYCLES : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RISE_W  = $clog2(FRAME_SCLKS + 1);

  localparam logic [CNT_W-1:0]  QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [RISE_W-1:0] RISE_FIRST = RISE_W'(LEAD_BITS);
  localparam logic [RISE_W-1:0] RISE_LAST  = RISE_W'(LEAD_BITS + DATA_BITS - 1);
  localparam logic [RISE_W-1:0] RISE_END   = RISE_W'(FRAME_SCLKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUIET = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [RISE_W-1:0]    r_rise;
  logic                 r_sclk;
  logic                 r_cs1;
  logic [DATA_BITS-1:0] r_sh1;
  logic [DATA_BITS-1:0] r_sh2;
  logic                 r_tvalid;
  logic [31:0]          r_tdata;
  logic                 r_overrun;

  logic w_tick;
  logic w_rise;
  logic w_fall;
  logic w_sample;
  logic w_publish;
  logic w_accept;
  logic w_load;

  function automatic logic [15:0] conv(input logic [DATA_BITS-1:0] s);
`ifdef ADC_SIGNED_CONV_EN
    // Flipping the MSB turns offset binary into two's complement at DATA_BITS width.
    logic signed [DATA_BITS-1:0] t;
    t = {~s[DATA_BITS-1], s[DATA_BITS-2:0]};
    return 16'(t);
`else
    return 16'(s);
`endif
  endfunction

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_tick = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next = QUIET;
        end
      end
      QUIET: begin
        if (r_cnt == QUIET_LAST) begin
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        w_tick = (r_cnt == DIV_LAST);
        if (w_tick && r_sclk && (r_rise == RISE_END)) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = enable ? QUIET : IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign w_rise    = w_tick & ~r_sclk;
  assign w_fall    = w_tick & r_sclk;
  assign w_sample  = w_fall && (r_rise >= RISE_FIRST) && (r_rise <= RISE_LAST);
  assign w_publish = (r_state == DONE);
  assign w_accept  = r_tvalid & m_axis_tready;
  assign w_load    = w_publish & (~r_tvalid | m_axis_tready);

  // One counter serves both the quiet gap and the SCLK half-period divider.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) || w_tick) begin
      r_cnt <= '0;
    end else if ((r_state == QUIET) || (r_state == SHIFT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_sclk <= 1'b0;
      r_rise <= '0;
      r_cs1  <= 1'b1;
    end else begin
      r_cs1 <= (w_next != SHIFT);
      if (w_next != SHIFT) begin
        r_sclk <= 1'b0;
      end else if (w_tick) begin
        r_sclk <= ~r_sclk;
      end
      if (r_state != SHIFT) begin
        r_rise <= '0;
      end else if (w_rise) begin
        r_rise <= r_rise + 1'b1;
      end
    end
  end

  // Sampling on the falling-edge tick gives the ADC a full half period to settle after its rise.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_sh1 <= '0;
      r_sh2 <= '0;
    end else if (w_sample) begin
      r_sh1 <= {r_sh1[DATA_BITS-2:0], adc1};
      r_sh2 <= {r_sh2[DATA_BITS-2:0], adc2};
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= {conv(r_sh2), conv(r_sh1)};
      end else begin
        // A publish that cannot load means the pending beat wins and this frame is lost.
        if (w_publish) begin
          r_overrun <= 1'b1;
        end
        if (w_accept) begin
          r_tvalid <= 1'b0;
        end
      end
    end
  end

  assign SPI_clk       = r_sclk;
  assign cs1           = r_cs1;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: ADC serial model, expected-beat queue, table vectors plus corner sequences.
module tb_adc_spi_capture;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        enable = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        adc1 = 1'b0;
  logic        adc2 = 1'b0;
  logic        SPI_clk;
  logic        cs1;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        overrun;

  adc_spi_capture dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .enable        (enable),
    .SPI_clk       (SPI_clk),
    .cs1           (cs1),
    .adc1          (adc1),
    .adc2          (adc2),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] conv(input logic [9:0] s);
`ifdef ADC_SIGNED_CONV_EN
    return 16'(int'(s) - 512);
`else
    return {6'b0, s};
`endif
  endfunction

  function automatic logic [31:0] expw(input logic [9:0] a1, input logic [9:0] a2);
    return {conv(a2), conv(a1)};
  endfunction

  // ADC model: zeros for 4 rises, then bits 9..0 driven after rises 4..13.
  logic [9:0] v1 = '0;
  logic [9:0] v2 = '0;
  logic [9:0] m_d1 = '0;
  logic [9:0] m_d2 = '0;
  int m_rise = 0;
  int total_rises = 0;

  always @(negedge cs1 or posedge SPI_clk) begin
    if (SPI_clk === 1'b1) begin
      m_rise++;
      total_rises++;
      if (m_rise >= 4 && m_rise <= 13) begin
        adc1 = m_d1[13-m_rise];
        adc2 = m_d2[13-m_rise];
      end else begin
        adc1 = 1'b0;
        adc2 = 1'b0;
      end
    end else begin
      m_rise = 0;
      m_d1 = v1;
      m_d2 = v2;
      adc1 = 1'b0;
      adc2 = 1'b0;
    end
  end

  always @(posedge cs1) begin
    if (reset_b && total_rises > 0) chk("sclk_rises_per_window", 32'(m_rise), 32'd16);
  end

  logic [31:0] exp_q[$];
  logic prev_tv = 1'b0;
  logic prev_sclk = 1'b0;
  logic per_chk = 1'b0;
  int last_fall_cyc = 0;
  int last_rise_cyc = 0;
  int ovr_cnt = 0;
  int beats = 0;

  always @(negedge clk) begin
    if (prev_sclk === 1'b1 && SPI_clk === 1'b0) last_fall_cyc = cyc;
    if (m_axis_tvalid === 1'b1 && prev_tv !== 1'b1) begin
      chk("tvalid_latency", 32'(cyc - last_fall_cyc), 32'd1);
      if (per_chk) chk("frame_period", 32'(cyc - last_rise_cyc), 32'd239);
      last_rise_cyc = cyc;
    end
    if (overrun === 1'b1) ovr_cnt++;
    if (m_axis_tvalid === 1'b1 && m_axis_tready === 1'b1) begin
      beats++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got 0x%08h with no beat expected", m_axis_tdata);
      end else begin
        chk("beat_data", m_axis_tdata, exp_q.pop_front());
      end
    end
    prev_tv = m_axis_tvalid;
    prev_sclk = SPI_clk;
  end

  task automatic wait_level(input logic want, input string nm);
    int n = 0;
    while (cs1 !== want && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    if (cs1 !== want) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, cs1=%b required %b", nm, cs1, want);
    end
  endtask

  task automatic wait_rises(input int n, input string nm);
    int k = 0;
    while (m_rise != n && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (m_rise != n) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, rises=%0d required %0d", nm, m_rise, n);
    end
  endtask

  task automatic wait_frame(input string nm);
    wait_level(1'b0, {nm, "_cs1_fall"});
    wait_level(1'b1, {nm, "_cs1_rise"});
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [9:0]  a1;
    logic [9:0]  a2;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea;
    int o0;
    int r0;
    int b0;
    int lowc;

`ifdef ADC_SIGNED_CONV_EN
    tbl[0] = '{10'h2A5, 10'h15A, 32'hFF5A_00A5};
    tbl[1] = '{10'h000, 10'h3FF, 32'h01FF_FE00};
    tbl[2] = '{10'h3FF, 10'h000, 32'hFE00_01FF};
    tbl[3] = '{10'h200, 10'h1FF, 32'hFFFF_0000};
    tbl[4] = '{10'h155, 10'h2AA, 32'h00AA_FF55};
`else
    tbl[0] = '{10'h2A5, 10'h15A, 32'h015A_02A5};
    tbl[1] = '{10'h000, 10'h3FF, 32'h03FF_0000};
    tbl[2] = '{10'h3FF, 10'h000, 32'h0000_03FF};
    tbl[3] = '{10'h200, 10'h1FF, 32'h01FF_0200};
    tbl[4] = '{10'h155, 10'h2AA, 32'h02AA_0155};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs1", 32'(cs1), 32'd1);
    chk("rst_sclk", 32'(SPI_clk), 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_b = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_cs1", 32'(cs1), 32'd1);
    chk("idle_sclk", 32'(SPI_clk), 32'd0);

    // Table vectors, free-running with tready=1.
    enable = 1'b1;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v1 = tbl[i].a1;
      v2 = tbl[i].a2;
      exp_q.push_back(tbl[i].exp);
      wait_frame("table");
      if (i == 0) per_chk = 1'b1;
    end
    per_chk = 1'b0;
    chk("table_q_empty", 32'(exp_q.size()), 32'd0);
    chk("table_no_overrun", 32'(ovr_cnt), 32'd0);

    // Backpressure across two frames.
    m_axis_tready = 1'b0;
    v1 = 10'h0F0;
    v2 = 10'h30F;
    ea = expw(10'h0F0, 10'h30F);
    exp_q.push_back(ea);
    wait_frame("bp_a");
    chk("bp_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("bp_hold_tdata", m_axis_tdata, ea);
    o0 = ovr_cnt;
    v1 = 10'h111;
    v2 = 10'h222;
    wait_frame("bp_b");
    chk("bp_overrun_once", 32'(ovr_cnt - o0), 32'd1);
    chk("bp_still_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("bp_still_tdata", m_axis_tdata, ea);
    v1 = 10'h3C3;
    v2 = 10'h03C;
    exp_q.push_back(expw(10'h3C3, 10'h03C));
    m_axis_tready = 1'b1;
    @(posedge clk); #1;
    chk("bp_accept_tvalid_low", 32'(m_axis_tvalid), 32'd0);
    chk("bp_accept_popped", 32'(exp_q.size()), 32'd1);
    wait_frame("bp_c");
    chk("bp_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a beat pending.
    m_axis_tready = 1'b0;
    v1 = 10'h0AA;
    v2 = 10'h355;
    wait_frame("rst_e");
    chk("rst_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
    wait_level(1'b0, "rst_mid_fall");
    wait_rises(8, "rst_rise8");
    chk("rst_pre_sclk_high", 32'(SPI_clk), 32'd1);
    reset_b = 1'b0;
    #1;
    chk("rst_mid_cs1", 32'(cs1), 32'd1);
    chk("rst_mid_sclk", 32'(SPI_clk), 32'd0);
    chk("rst_mid_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mid_tdata", m_axis_tdata, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    m_axis_tready = 1'b1;
    v1 = 10'h1E1;
    v2 = 10'h2D2;
    exp_q.push_back(expw(10'h1E1, 10'h2D2));
    reset_b = 1'b1;
    wait_frame("rst_f");
    chk("rst_q_empty", 32'(exp_q.size()), 32'd0);

    // enable drops at SCLK rise 3.
    v1 = 10'h07F;
    v2 = 10'h380;
    exp_q.push_back(expw(10'h07F, 10'h380));
    wait_level(1'b0, "en_fall");
    wait_rises(3, "en_rise3");
    enable = 1'b0;
    wait_level(1'b1, "en_rise");
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("en_frame_published", 32'(exp_q.size()), 32'd0);
    r0 = total_rises;
    lowc = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (cs1 !== 1'b1) lowc++;
    end
    chk("en_cs1_stays_high", 32'(lowc), 32'd0);
    chk("en_no_sclk", 32'(total_rises - r0), 32'd0);

    // 256-sample ramp on both channels.
    enable = 1'b1;
    o0 = ovr_cnt;
    b0 = beats;
    for (int i = 0; i < 256; i++) begin
      v1 = 10'(i);
      v2 = 10'(i);
      exp_q.push_back(expw(10'(i), 10'(i)));
      wait_frame("ramp");
      if (i == 0) per_chk = 1'b1;
    end
    per_chk = 1'b0;
    chk("ramp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("ramp_beats", 32'(beats - b0), 32'd256);
    chk("ramp_no_overrun", 32'(ovr_cnt - o0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
